key_matrix_scan: RTL

//  Upstream stage of the EP1 keyboard endpoint: scans the 4x4 key matrix (row/line pins at
//  top level), synchronises and debounces it, and presents a stable 16-bit pressed-key map.

---
 rtl/key_matrix_scan.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/key_matrix_scan.sv
// 4x4 key matrix scanner: row drive, line synchronisation, frame debounce and change handshake.
// Optional ghost-frame rejection is built when GHOST_BLOCK_EN is defined.
module key_matrix_scan #(
  parameter int unsigned SCAN_DIV     = 6000,
  parameter int unsigned DEBOUNCE_CNT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  line,
  output logic [3:0]  row,
  output logic [15:0] keys,
  output logic        chg_valid,
  input  logic        chg_ack,
  output logic        ghost
);

  localparam int unsigned DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned STAB_W = (DEBOUNCE_CNT > 0) ? $clog2(DEBOUNCE_CNT + 1) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {ROW0, ROW1, ROW2, ROW3} row_state_t;

  row_state_t        state, state_next;
  logic [3:0]        line_meta, line_sync;
  logic [3:0]        sample;
  logic [DIV_W-1:0]  div_cnt;
  logic              div_last;
  logic              frame_end;
  logic [11:0]       raw;
  logic [15:0]       frame;
  logic [15:0]       prev_f;
  logic [STAB_W-1:0] stab, stab_next;
  logic              commit;
  logic              frame_ghost;

  assign sample    = ~line_sync;
  assign div_last  = (div_cnt == DIV_LAST);
  assign frame_end = div_last && (state == ROW3);
  // Row 3 is never latched into raw: the frame is assembled from the live sample.
  assign frame     = {sample, raw};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ROW0;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    row        = 4'b1110;
    case (state)
      ROW0: begin
        row = 4'b1110;
        if (div_last) state_next = ROW1;
      end
      ROW1: begin
        row = 4'b1101;
        if (div_last) state_next = ROW2;
      end
      ROW2: begin
        row = 4'b1011;
        if (div_last) state_next = ROW3;
      end
      ROW3: begin
        row = 4'b0111;
        if (div_last) state_next = ROW0;
      end
      default: state_next = ROW0;
    endcase
  end

  // Synchroniser idles at the pulled-up level so reset does not look like a full press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_meta <= '1;
      line_sync <= '1;
      div_cnt   <= '0;
      raw       <= '0;
    end else begin
      line_meta <= line;
      line_sync <= line_meta;
      if (div_last) begin
        div_cnt <= '0;
        case (state)
          ROW0:    raw[3:0]  <= sample;
          ROW1:    raw[7:4]  <= sample;
          ROW2:    raw[11:8] <= sample;
          default: ;
        endcase
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

`ifdef GHOST_BLOCK_EN
  function automatic logic is_ghosted(input logic [15:0] f);
    logic       hit;
    logic [3:0] both;
    hit = 1'b0;
    for (int unsigned a = 0; a < 4; a++) begin
      for (int unsigned b = a + 1; b < 4; b++) begin
        both = f[a*4 +: 4] & f[b*4 +: 4];
        if ($countones(both) >= 2) hit = 1'b1;
      end
    end
    return hit;
  endfunction

  assign frame_ghost = is_ghosted(frame);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            ghost <= 1'b0;
    else if (frame_end) ghost <= frame_ghost;
  end
`else
  assign frame_ghost = 1'b0;
  assign ghost       = 1'b0;
`endif

  always_comb begin
    stab_next = stab;
    if (frame_ghost || (frame != prev_f)) stab_next = '0;
    else if (stab < STAB_MAX)             stab_next = stab + 1'b1;
    commit = !frame_ghost && (stab_next == STAB_MAX) && (stab != STAB_MAX) && (frame != keys);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_f    <= '0;
      stab      <= '0;
      keys      <= '0;
      chg_valid <= 1'b0;
    end else begin
      if (frame_end) begin
        prev_f <= frame;
        stab   <= stab_next;
        if (commit) keys <= frame;
      end
      // A commit in the ack cycle keeps the change pending.
      if (frame_end && commit) chg_valid <= 1'b1;
      else if (chg_ack)        chg_valid <= 1'b0;
    end
  end

endmodule
